// File: rtl/interrupt_sequencer.sv
// Interrupt/reset/RTI sequencer: stacks CPU context, fetches vectors and
// restores context from the stack, one bus access per cycle.
module interrupt_sequencer #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RST_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
    input  logic               clk,
    input  logic               rst,
    output logic [15:0]        mem_addr,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    input  logic [7:0]         mem_rdata,
    input  logic               nmi_in,
    input  logic               soft_reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               brk,
    input  logic               rti,
    input  logic               start,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         status_in,
    input  logic [7:0]         sp_in,
    output logic [15:0]        pc_out,
    output logic [7:0]         status_out,
    output logic [7:0]         sp_out,
    output logic               busy,
    output logic               done,
    output logic [NUM_IRQ-1:0] irq_ack
);

    typedef enum logic [3:0] {
        S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI,
        S_VEC_CAP, S_POP_P, S_POP_PCL, S_POP_PCH, S_POP_CAP
    } state_e;

    typedef enum logic [2:0] {
        K_NONE, K_RST, K_NMI, K_BRK, K_RTI, K_IRQ
    } kind_e;

    state_e             state_q, state_d;
    kind_e              kind_q, kind_d;
    logic [15:0]        pc_q, pc_d;
    logic [7:0]         p_q, p_d;
    logic [7:0]         sp_q, sp_d;
    logic [NUM_IRQ-1:0] ack_sel_q, ack_sel_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         pop_p_q, pop_p_d;
    logic [7:0]         pop_pcl_q, pop_pcl_d;
    logic               nmi_q;
    logic               nmi_pend_q, nmi_pend_d;
    logic               rst_pend_q, rst_pend_d;
    logic [15:0]        pc_out_q, pc_out_d;
    logic [7:0]         status_out_q, status_out_d;
    logic [7:0]         sp_out_q, sp_out_d;
    logic               done_q, done_d;
    logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;

    logic               nmi_edge;
    logic               nmi_clr;
    logic               rst_clr;
    logic [NUM_IRQ-1:0] irq_pend;
    logic [NUM_IRQ-1:0] irq_first;
    logic               irq_req;
    logic [7:0]         push_p;
    logic [15:0]        vec;

    // Request qualification: NMI edge, enabled IRQs and lowest-index winner
    always_comb begin
        nmi_edge  = nmi_in & ~nmi_q;
        irq_pend  = irq_in & irq_mask;
        irq_first = irq_pend & (~irq_pend + NUM_IRQ'(1));
        irq_req   = (|irq_pend) & ~status_in[2];
    end

    // Stacked status and vector address depend on the action being served
    always_comb begin
        push_p = {p_q[7:6], 1'b1, (kind_q == K_BRK), p_q[3:0]};
        case (kind_q)
            K_RST:   vec = RST_VEC;
            K_NMI:   vec = NMI_VEC;
            default: vec = IRQ_VEC;
        endcase
    end

    // Pending flags: a new event wins over the clear on service entry
    always_comb begin
        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
        rst_pend_d = (rst_pend_q & ~rst_clr) | soft_reset;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        pc_d         = pc_q;
        p_d          = p_q;
        sp_d         = sp_q;
        ack_sel_d    = ack_sel_q;
        lo_d         = lo_q;
        pop_p_d      = pop_p_q;
        pop_pcl_d    = pop_pcl_q;
        pc_out_d     = pc_out_q;
        status_out_d = status_out_q;
        sp_out_d     = sp_out_q;
        done_d       = 1'b0;
        irq_ack_d    = '0;
        nmi_clr      = 1'b0;
        rst_clr      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d      = pc_in;
                    p_d       = status_in;
                    sp_d      = sp_in;
                    ack_sel_d = '0;
                    if (rst_pend_q) begin
                        kind_d  = K_RST;
                        rst_clr = 1'b1;
                        state_d = S_VEC_LO;
                    end else if (nmi_pend_q) begin
                        kind_d  = K_NMI;
                        nmi_clr = 1'b1;
                        state_d = S_PUSH_PCH;
                    end else if (brk) begin
                        kind_d  = K_BRK;
                        state_d = S_PUSH_PCH;
                    end else if (rti) begin
                        kind_d  = K_RTI;
                        state_d = S_POP_P;
                    end else if (irq_req) begin
                        kind_d    = K_IRQ;
                        ack_sel_d = irq_first;
                        state_d   = S_PUSH_PCH;
                    end else begin
                        kind_d       = K_NONE;
                        pc_out_d     = pc_in;
                        status_out_d = status_in;
                        sp_out_d     = sp_in;
                        done_d       = 1'b1;
                    end
                end
            end
            S_PUSH_PCH: state_d = S_PUSH_PCL;
            S_PUSH_PCL: state_d = S_PUSH_P;
            S_PUSH_P:   state_d = S_VEC_LO;
            S_VEC_LO:   state_d = S_VEC_HI;
            S_VEC_HI: begin
                lo_d    = mem_rdata;
                state_d = S_VEC_CAP;
            end
            S_VEC_CAP: begin
                pc_out_d     = {mem_rdata, lo_q};
                status_out_d = push_p | 8'h04;
                sp_out_d     = 8'(sp_q - 8'd3);
                irq_ack_d    = ack_sel_q;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            S_POP_P:    state_d = S_POP_PCL;
            S_POP_PCL: begin
                pop_p_d = mem_rdata;
                state_d = S_POP_PCH;
            end
            S_POP_PCH: begin
                pop_pcl_d = mem_rdata;
                state_d   = S_POP_CAP;
            end
            S_POP_CAP: begin
                pc_out_d     = {mem_rdata, pop_pcl_q};
                status_out_d = (pop_p_q & 8'hCF) | 8'h20;
                sp_out_d     = 8'(sp_q + 8'd3);
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus decode from the current state; idle and capture states keep the bus at zero
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            S_PUSH_PCH: begin
                mem_addr  = {STACK_PAGE, sp_q};
                mem_wdata = pc_q[15:8];
                mem_we    = 1'b1;
            end
            S_PUSH_PCL: begin
                mem_addr  = {STACK_PAGE, 8'(sp_q - 8'd1)};
                mem_wdata = pc_q[7:0];
                mem_we    = 1'b1;
            end
            S_PUSH_P: begin
                mem_addr  = {STACK_PAGE, 8'(sp_q - 8'd2)};
                mem_wdata = push_p;
                mem_we    = 1'b1;
            end
            S_VEC_LO:  mem_addr = vec;
            S_VEC_HI:  mem_addr = 16'(vec + 16'd1);
            S_POP_P:   mem_addr = {STACK_PAGE, 8'(sp_q + 8'd1)};
            S_POP_PCL: mem_addr = {STACK_PAGE, 8'(sp_q + 8'd2)};
            S_POP_PCH: mem_addr = {STACK_PAGE, 8'(sp_q + 8'd3)};
            default: ;
        endcase
    end

    // State and context registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            kind_q       <= K_NONE;
            pc_q         <= '0;
            p_q          <= '0;
            sp_q         <= '0;
            ack_sel_q    <= '0;
            lo_q         <= '0;
            pop_p_q      <= '0;
            pop_pcl_q    <= '0;
            nmi_q        <= 1'b0;
            nmi_pend_q   <= 1'b0;
            rst_pend_q   <= 1'b0;
            pc_out_q     <= '0;
            status_out_q <= '0;
            sp_out_q     <= '0;
            done_q       <= 1'b0;
            irq_ack_q    <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            pc_q         <= pc_d;
            p_q          <= p_d;
            sp_q         <= sp_d;
            ack_sel_q    <= ack_sel_d;
            lo_q         <= lo_d;
            pop_p_q      <= pop_p_d;
            pop_pcl_q    <= pop_pcl_d;
            nmi_q        <= nmi_in;
            nmi_pend_q   <= nmi_pend_d;
            rst_pend_q   <= rst_pend_d;
            pc_out_q     <= pc_out_d;
            status_out_q <= status_out_d;
            sp_out_q     <= sp_out_d;
            done_q       <= done_d;
            irq_ack_q    <= irq_ack_d;
        end
    end

    // Output assignments
    always_comb begin
        busy       = (state_q != S_IDLE);
        pc_out     = pc_out_q;
        status_out = status_out_q;
        sp_out     = sp_out_q;
        done       = done_q;
        irq_ack    = irq_ack_q;
    end

endmodule
